// File: rtl/main_mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter and the caches on either side of it.
// Holds default widths and the arbiter state encoding.
package main_mem_arbiter_pkg;

   localparam int unsigned DefAddrW       = 28;
   localparam int unsigned DefDataW       = 128;
   localparam int unsigned DefStarveLimit = 4;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t StIdle     = 3'd0;
   localparam arb_state_t StGrantI   = 3'd1;
   localparam arb_state_t StGrantD   = 3'd2;
   localparam arb_state_t StReleaseI = 3'd3;
   localparam arb_state_t StReleaseD = 3'd4;

endpackage

// File: rtl/main_mem_arbiter.sv
// Arbitrates one block-wide main-memory port between the I-cache (read-only) and the D-cache.
// D has priority; a saturating counter forces an I grant after STARVE_LIMIT D grants in a row.
module main_mem_arbiter
   import main_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = DefAddrW,
   parameter int unsigned DATA_W       = DefDataW,
   parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_read,
   input  logic [ADDR_W-1:0] i_mem_address,
   output logic [DATA_W-1:0] i_mem_readdata,
   output logic              i_mem_busywait,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_address,
   input  logic [DATA_W-1:0] d_mem_writedata,
   output logic [DATA_W-1:0] d_mem_readdata,
   output logic              d_mem_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_busywait
);

   localparam int unsigned     CntW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   arb_state_t        state_q, state_d;
   logic              first_q, first_d;
   logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic i_req, d_req, i_wins, done;

   assign i_req  = i_mem_read;
   assign d_req  = d_mem_read | d_mem_write;
   assign i_wins = i_req && (!d_req || (starve_cnt_q == CntMax));
   // The first grant cycle is ignored: memory has not yet seen the strobe.
   assign done   = !first_q && !mem_busywait;

   always_comb begin
      state_d         = state_q;
      first_d         = 1'b0;
      starve_cnt_d    = starve_cnt_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      i_rdata_d       = i_rdata_q;
      d_rdata_d       = d_rdata_q;
      case (state_q)
         StIdle: begin
            if (i_wins) begin
               state_d       = StGrantI;
               first_d       = 1'b1;
               starve_cnt_d  = '0;
               mem_read_d    = 1'b1;
               mem_write_d   = 1'b0;
               mem_address_d = i_mem_address;
            end else if (d_req) begin
               state_d         = StGrantD;
               first_d         = 1'b1;
               mem_read_d      = !d_mem_write;
               mem_write_d     = d_mem_write;
               mem_address_d   = d_mem_address;
               mem_writedata_d = d_mem_writedata;
               if (i_req && (starve_cnt_q != CntMax)) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
            end
         end
         StGrantI, StGrantD: begin
            if (done) begin
               state_d     = (state_q == StGrantI) ? StReleaseI : StReleaseD;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q && (state_q == StGrantI)) i_rdata_d = mem_readdata;
               if (mem_read_q && (state_q == StGrantD)) d_rdata_d = mem_readdata;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= StIdle;
         first_q         <= 1'b0;
         starve_cnt_q    <= '0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         i_rdata_q       <= '0;
         d_rdata_q       <= '0;
      end else begin
         state_q         <= state_d;
         first_q         <= first_d;
         starve_cnt_q    <= starve_cnt_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         i_rdata_q       <= i_rdata_d;
         d_rdata_q       <= d_rdata_d;
      end
   end

   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_writedata  = mem_writedata_q;
   assign i_mem_readdata = i_rdata_q;
   assign d_mem_readdata = d_rdata_q;
   assign i_mem_busywait = i_req && (state_q != StReleaseI);
   assign d_mem_busywait = d_req && (state_q != StReleaseD);

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: directed scenarios plus randomized traffic
// against a block-memory scoreboard and latency/ordering rules.
module tb_main_mem_arbiter;

   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_mem_read = 1'b0;
   logic [AW-1:0] i_mem_address = '0;
   logic [DW-1:0] i_mem_readdata;
   logic          i_mem_busywait;
   logic          d_mem_read = 1'b0;
   logic          d_mem_write = 1'b0;
   logic [AW-1:0] d_mem_address = '0;
   logic [DW-1:0] d_mem_writedata = '0;
   logic [DW-1:0] d_mem_readdata;
   logic          d_mem_busywait;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata = '0;
   logic          mem_busywait = 1'b0;

   main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
      .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
      .d_mem_writedata(d_mem_writedata), .d_mem_readdata(d_mem_readdata),
      .d_mem_busywait(d_mem_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int lat = 1;
   int busy_cnt = 0;
   logic [DW-1:0] mem_model [64];
   logic [63:0]   mem_v = '0;
   logic [DW-1:0] ref_mem [64];
   logic [63:0]   ref_v = '0;
   logic [7:0]    grants [$];
   logic          strobe_prev = 1'b0;

   function automatic logic [5:0] idx(input logic [AW-1:0] a);
      return {a[AW-1], a[4:0]};
   endfunction

   // Initial memory image: known pattern everywhere, 0xA5 block at 0x10.
   function automatic logic [DW-1:0] image(input logic [AW-1:0] a);
      if (a == 28'h0000010) return {16{8'hA5}};
      return {4{a, 4'h9}} ^ {4{32'hC3C3_5A5A}};
   endfunction

   function automatic logic [DW-1:0] fetch(input logic [AW-1:0] a);
      if (mem_v[idx(a)]) return mem_model[idx(a)];
      return image(a);
   endfunction

   function automatic logic [DW-1:0] ref_expect(input logic [AW-1:0] a);
      if (ref_v[idx(a)]) return ref_mem[idx(a)];
      return image(a);
   endfunction

   // Main memory: busy for lat cycles from the first strobe cycle.
   always @(posedge clk) begin
      if (mem_write && !mem_busywait) begin
         mem_model[idx(mem_address)] <= mem_writedata;
         mem_v[idx(mem_address)]     <= 1'b1;
      end
      busy_cnt <= (mem_read || mem_write) ? busy_cnt + 1 : 0;
   end

   always @(negedge clk) begin
      mem_busywait <= (mem_read || mem_write) && (busy_cnt < lat);
      mem_readdata <= fetch(mem_address);
      if ((mem_read || mem_write) && !strobe_prev) begin
         grants.push_back(mem_address[AW-1] ? 8'h44 : 8'h49);
      end
      strobe_prev <= mem_read || mem_write;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i_access(input logic [AW-1:0] a, output logic [DW-1:0] data, output int dur);
      i_mem_address = a;
      i_mem_read    = 1'b1;
      dur           = 0;
      do begin tick(); dur++; end while (i_mem_busywait && dur < 100);
      data       = i_mem_readdata;
      i_mem_read = 1'b0;
   endtask

   task automatic d_access(input logic [AW-1:0] a, input logic rd, input logic wr,
                           input logic [DW-1:0] wd, output logic [DW-1:0] data, output int dur);
      d_mem_address   = a;
      d_mem_read      = rd;
      d_mem_write     = wr;
      d_mem_writedata = wd;
      dur             = 0;
      do begin tick(); dur++; end while (d_mem_busywait && dur < 100);
      data        = d_mem_readdata;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
   endtask

   function automatic int lone_lat(input int l);
      return ((l < 1) ? 1 : l) + 2;
   endfunction

   initial begin
      logic [DW-1:0] di, dd, last_d, wd;
      int            ti, td, dur, mode;
      logic [AW-1:0] ai, ad;
      logic [AW-1:0] d5 [5];
      logic [7:0]    exp_g [6];
      logic          rd;

      // Reset state
      #12;
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_writedata", mem_writedata, 0);
      check("rst_i_readdata", i_mem_readdata, 0);
      check("rst_d_readdata", d_mem_readdata, 0);
      check("rst_d_busywait_idle", d_mem_busywait, 0);
      i_mem_read = 1'b1;
      #1 check("rst_i_busywait_req", i_mem_busywait, 1);
      i_mem_read = 1'b0;
      #1 check("rst_i_busywait_idle", i_mem_busywait, 0);
      rst = 1'b1;
      tick();

      // Lone I read, memory latency 3
      lat = 3;
      i_mem_address = 28'h0000010;
      i_mem_read    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("lone_i_mem_read_c%0d", k), mem_read, (k <= 4));
         check($sformatf("lone_i_busywait_c%0d", k), i_mem_busywait, (k != 5));
      end
      check("lone_i_readdata", i_mem_readdata, {16{8'hA5}});
      check("lone_i_address", mem_address, 28'h0000010);
      i_mem_read = 1'b0;
      tick();
      check("lone_i_idle_read", mem_read, 0);
      check("lone_i_idle_busy", i_mem_busywait, 0);

      // Simultaneous requests: D first, I after D release
      lat = 1;
      grants.delete();
      fork
         i_access(28'h0000020, di, ti);
         d_access({1'b1, 27'h1}, 1'b1, 1'b0, '0, dd, td);
      join
      check("both_grant_cnt", grants.size(), 2);
      check("both_grant0_D", grants[0], 8'h44);
      check("both_grant1_I", grants[1], 8'h49);
      check("both_d_release", td, 3);
      check("both_i_release", ti, 7);
      check("both_i_data", di, ref_expect(28'h0000020));
      check("both_d_data", dd, ref_expect({1'b1, 27'h1}));
      tick();

      // Starvation: five back-to-back D requests with I pending
      grants.delete();
      exp_g = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
      for (int k = 0; k < 5; k++) d5[k] = {1'b1, 22'b0, 5'(k + 2)};
      fork
         i_access(28'h0000030, di, ti);
         for (int k = 0; k < 5; k++) d_access(d5[k], 1'b1, 1'b0, '0, last_d, dur);
      join
      check("starve_grant_cnt", grants.size(), 6);
      for (int k = 0; k < 6; k++) check($sformatf("starve_grant%0d", k), grants[k], exp_g[k]);
      check("starve_i_data", di, ref_expect(28'h0000030));
      check("starve_d_last_data", last_d, ref_expect(d5[4]));
      tick();

      // D read+write together is a write
      lat = 2;
      ad = {1'b1, 22'b0, 5'd12};
      d_mem_address   = ad;
      d_mem_read      = 1'b1;
      d_mem_write     = 1'b1;
      d_mem_writedata = 128'h1234;
      tick();
      check("rw_mem_write", mem_write, 1);
      check("rw_mem_read", mem_read, 0);
      check("rw_mem_writedata", mem_writedata, 128'h1234);
      check("rw_mem_address", mem_address, ad);
      dur = 1;
      while (d_mem_busywait && dur < 100) begin tick(); dur++; end
      check("rw_release", dur, 4);
      check("rw_readdata_kept", d_mem_readdata, ref_expect(d5[4]));
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      ref_mem[idx(ad)] = 128'h1234;
      ref_v[idx(ad)]   = 1'b1;
      tick();
      d_access(ad, 1'b1, 1'b0, '0, dd, dur);
      check("rw_readback", dd, ref_expect(ad));
      tick();

      // Zero-latency memory
      lat = 0;
      grants.delete();
      ad = {1'b1, 22'b0, 5'd20};
      d_mem_address = ad;
      d_mem_read    = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("zl_mem_read_c%0d", k), mem_read, (k <= 2));
         if (k <= 3) check($sformatf("zl_busywait_c%0d", k), d_mem_busywait, (k != 3));
         if (k == 3) begin
            check("zl_data", d_mem_readdata, ref_expect(ad));
            d_mem_read = 1'b0;
         end
      end
      check("zl_single_grant", grants.size(), 1);

      // Randomized traffic against the scoreboard
      for (int n = 0; n < 40; n++) begin
         tick();
         lat  = $urandom_range(0, 3);
         mode = $urandom_range(0, 3);
         ai   = {1'b0, 22'b0, 5'($urandom_range(0, 31))};
         ad   = {1'b1, 22'b0, 5'($urandom_range(0, 31))};
         wd   = {$urandom, $urandom, $urandom, $urandom};
         rd   = 1'($urandom_range(0, 1));
         case (mode)
            0: begin
               i_access(ai, di, ti);
               check($sformatf("rnd%0d_i_data", n), di, ref_expect(ai));
               check($sformatf("rnd%0d_i_lat", n), ti, lone_lat(lat));
            end
            1: begin
               d_access(ad, 1'b1, 1'b0, '0, dd, td);
               check($sformatf("rnd%0d_d_data", n), dd, ref_expect(ad));
               check($sformatf("rnd%0d_d_lat", n), td, lone_lat(lat));
            end
            2: begin
               d_access(ad, rd, 1'b1, wd, dd, td);
               check($sformatf("rnd%0d_w_lat", n), td, lone_lat(lat));
               ref_mem[idx(ad)] = wd;
               ref_v[idx(ad)]   = 1'b1;
            end
            default: begin
               fork
                  i_access(ai, di, ti);
                  d_access(ad, rd, !rd, wd, dd, td);
               join
               check($sformatf("rnd%0d_par_i_data", n), di, ref_expect(ai));
               if (rd) check($sformatf("rnd%0d_par_d_data", n), dd, ref_expect(ad));
               else begin
                  ref_mem[idx(ad)] = wd;
                  ref_v[idx(ad)]   = 1'b1;
               end
               check($sformatf("rnd%0d_par_d_lat", n), td, lone_lat(lat));
               check($sformatf("rnd%0d_par_i_lat", n), ti, td + lone_lat(lat) + 1);
            end
         endcase
      end

      // Reset in the middle of a D write
      tick();
      lat = 3;
      d_mem_address   = {1'b1, 22'b0, 5'd7};
      d_mem_writedata = 128'hBEEF;
      d_mem_write     = 1'b1;
      tick();
      tick();
      check("midrst_pre_write", mem_write, 1);
      rst = 1'b0;
      #1;
      check("midrst_mem_write", mem_write, 0);
      check("midrst_mem_address", mem_address, 0);
      check("midrst_mem_writedata", mem_writedata, 0);
      check("midrst_i_readdata", i_mem_readdata, 0);
      check("midrst_d_readdata", d_mem_readdata, 0);
      check("midrst_d_busywait", d_mem_busywait, 1);
      d_mem_write = 1'b0;
      #1 rst = 1'b1;
      tick();
      check("midrst_after_idle", mem_write, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
